// File: rtl/mcl86_bus_arbiter.sv
// rtl/mcl86_bus_arbiter.sv - HOLD/HLDA arbiter sharing the 8088 external bus with one secondary master
module mcl86_bus_arbiter #(
    parameter int DEAD_CYCLES    = 1,
    parameter int MIN_CPU_CYCLES = 4
) (
    input  logic        CORE_CLK_INT,
    input  logic        RESET_INT,

    input  logic        CPU_ALE,
    input  logic        CPU_RD_n,
    input  logic        CPU_WR_n,
    input  logic        CPU_IOM,
    input  logic        CPU_INTA_n,
    input  logic        CPU_DTR,
    input  logic        CPU_DEN,
    input  logic        CPU_AD_OE,
    input  logic [19:0] CPU_AD_OUT,
    input  logic        CPU_LOCK,
    output logic        CPU_READY,

    input  logic        DMA_HOLD,
    output logic        DMA_HLDA,
    input  logic        DMA_ALE,
    input  logic        DMA_RD_n,
    input  logic        DMA_WR_n,
    input  logic        DMA_IOM,
    input  logic        DMA_AD_OE,
    input  logic [19:0] DMA_AD_OUT,
    output logic        DMA_READY,

    input  logic        BUS_READY,
    output logic        BUS_ALE,
    output logic        BUS_RD_n,
    output logic        BUS_WR_n,
    output logic        BUS_IOM,
    output logic        BUS_INTA_n,
    output logic        BUS_DTR,
    output logic        BUS_DEN,
    output logic        BUS_AD_OE,
    output logic [19:0] BUS_AD_OUT,
    output logic        BUS_OWNER
);

    typedef enum logic [2:0] {
        ST_CPU_OWN     = 3'd0,
        ST_DEAD_TO_DMA = 3'd1,
        ST_DMA_OWN     = 3'd2,
        ST_DEAD_TO_CPU = 3'd3,
        ST_CPU_REPLAY  = 3'd4
    } state_t;

    localparam logic [2:0] DEAD_LOAD  = 3'(DEAD_CYCLES - 1);
    localparam logic [3:0] GUARD_LOAD = 4'(MIN_CPU_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  dead_cnt_q, dead_cnt_d;
    logic [3:0]  guard_q, guard_d;
    logic        pend_q, pend_d;
    logic [19:0] replay_ad_q, replay_ad_d;
    logic        replay_iom_q, replay_iom_d;
    logic        cpu_busy_q, cpu_busy_d;
    logic        strobe_seen_q, strobe_seen_d;
    logic        inta_seen_q, inta_seen_d;
    logic        inta_half_q, inta_half_d;
    logic        hlda_q, hlda_d;
    logic        owner_q, owner_d;

    logic        cpu_side;
    logic        strobe_low;
    logic        grant_ok;

    assign cpu_side   = (state_q == ST_CPU_OWN) || (state_q == ST_CPU_REPLAY);
    assign strobe_low = ~CPU_RD_n | ~CPU_WR_n | ~CPU_INTA_n;
    assign grant_ok   = DMA_HOLD && !cpu_busy_q && !inta_half_q && !CPU_LOCK &&
                        !CPU_ALE && (guard_q == 4'd0);

    always_comb begin
        state_d       = state_q;
        dead_cnt_d    = dead_cnt_q;
        guard_d       = guard_q;
        pend_d        = pend_q;
        replay_ad_d   = replay_ad_q;
        replay_iom_d  = replay_iom_q;
        cpu_busy_d    = cpu_busy_q;
        strobe_seen_d = strobe_seen_q;
        inta_seen_d   = inta_seen_q;
        inta_half_d   = inta_half_q;

        // Cycle tracking; an ALE in the completion clock starts the next cycle, so it is applied last.
        if (cpu_side) begin
            if (guard_q != 4'd0) begin
                guard_d = guard_q - 4'd1;
            end
            if (strobe_low) begin
                strobe_seen_d = 1'b1;
                if (!CPU_INTA_n) begin
                    inta_seen_d = 1'b1;
                end
            end else if (strobe_seen_q) begin
                cpu_busy_d    = 1'b0;
                strobe_seen_d = 1'b0;
                inta_seen_d   = 1'b0;
                if (inta_seen_q) begin
                    inta_half_d = ~inta_half_q;
                end
            end
            if (CPU_ALE) begin
                cpu_busy_d = 1'b1;
            end
        end

        // A CPU cycle started while the bus is away is captured for replay; a second one is dropped.
        if (!cpu_side && CPU_ALE && !pend_q) begin
            pend_d       = 1'b1;
            replay_ad_d  = CPU_AD_OUT;
            replay_iom_d = CPU_IOM;
        end

        case (state_q)
            ST_CPU_OWN: begin
                if (grant_ok) begin
                    state_d    = ST_DEAD_TO_DMA;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            ST_DEAD_TO_DMA: begin
                if (dead_cnt_q == 3'd0) begin
                    state_d = ST_DMA_OWN;
                end else begin
                    dead_cnt_d = dead_cnt_q - 3'd1;
                end
            end
            ST_DMA_OWN: begin
                if (!DMA_HOLD) begin
                    state_d    = ST_DEAD_TO_CPU;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            ST_DEAD_TO_CPU: begin
                if (dead_cnt_q == 3'd0) begin
                    state_d = pend_d ? ST_CPU_REPLAY : ST_CPU_OWN;
                    guard_d = GUARD_LOAD;
                end else begin
                    dead_cnt_d = dead_cnt_q - 3'd1;
                end
            end
            ST_CPU_REPLAY: begin
                state_d    = ST_CPU_OWN;
                pend_d     = 1'b0;
                cpu_busy_d = 1'b1;
            end
            default: begin
                state_d = ST_CPU_OWN;
            end
        endcase

        hlda_d  = (state_d == ST_DMA_OWN);
        owner_d = (state_d == ST_DMA_OWN);
    end

    always_ff @(posedge CORE_CLK_INT) begin
        if (RESET_INT) begin
            state_q       <= ST_CPU_OWN;
            dead_cnt_q    <= 3'd0;
            guard_q       <= 4'd0;
            pend_q        <= 1'b0;
            replay_ad_q   <= 20'd0;
            replay_iom_q  <= 1'b0;
            cpu_busy_q    <= 1'b0;
            strobe_seen_q <= 1'b0;
            inta_seen_q   <= 1'b0;
            inta_half_q   <= 1'b0;
            hlda_q        <= 1'b0;
            owner_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dead_cnt_q    <= dead_cnt_d;
            guard_q       <= guard_d;
            pend_q        <= pend_d;
            replay_ad_q   <= replay_ad_d;
            replay_iom_q  <= replay_iom_d;
            cpu_busy_q    <= cpu_busy_d;
            strobe_seen_q <= strobe_seen_d;
            inta_seen_q   <= inta_seen_d;
            inta_half_q   <= inta_half_d;
            hlda_q        <= hlda_d;
            owner_q       <= owner_d;
        end
    end

    assign DMA_HLDA  = hlda_q;
    assign BUS_OWNER = owner_q;

    always_comb begin
        BUS_ALE    = 1'b0;
        BUS_RD_n   = 1'b1;
        BUS_WR_n   = 1'b1;
        BUS_IOM    = 1'b0;
        BUS_INTA_n = 1'b1;
        BUS_DTR    = 1'b0;
        BUS_DEN    = 1'b1;
        BUS_AD_OE  = 1'b0;
        BUS_AD_OUT = 20'd0;
        CPU_READY  = 1'b0;
        DMA_READY  = 1'b0;

        case (state_q)
            ST_CPU_OWN: begin
                BUS_ALE    = CPU_ALE;
                BUS_RD_n   = CPU_RD_n;
                BUS_WR_n   = CPU_WR_n;
                BUS_IOM    = CPU_IOM;
                BUS_INTA_n = CPU_INTA_n;
                BUS_DTR    = CPU_DTR;
                BUS_DEN    = CPU_DEN;
                BUS_AD_OE  = CPU_AD_OE;
                BUS_AD_OUT = CPU_AD_OUT;
                CPU_READY  = BUS_READY;
            end
            ST_DMA_OWN: begin
                BUS_ALE    = DMA_ALE;
                BUS_RD_n   = DMA_RD_n;
                BUS_WR_n   = DMA_WR_n;
                BUS_IOM    = DMA_IOM;
                BUS_DTR    = ~DMA_WR_n;
                BUS_DEN    = DMA_RD_n & DMA_WR_n;
                BUS_AD_OE  = DMA_AD_OE;
                BUS_AD_OUT = DMA_AD_OUT;
                DMA_READY  = BUS_READY;
            end
            ST_CPU_REPLAY: begin
                BUS_ALE    = 1'b1;
                BUS_AD_OE  = 1'b1;
                BUS_AD_OUT = replay_ad_q;
                BUS_IOM    = replay_iom_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mcl86_bus_arbiter.md
Name: mcl86_bus_arbiter

Overview:
Shares the 8088 external bus (ALE/RD_n/WR_n/IOM/INTA_n/DTR/DEN/AD) between the minimum-mode CPU core and one secondary bus master, such as a DMA engine. It uses a HOLD/HLDA handshake and never preempts a CPU bus cycle in flight. If the CPU starts a cycle while it does not own the bus, the block stalls the CPU via READY, latches its address, and replays the ALE phase when the bus returns. It sits between the cpu_8088 pins and the system bus/memory decode.

Parameters:
DEAD_CYCLES, 1, bus turnaround clocks (all bus outputs inactive) on every ownership change; legal range 1-7.
MIN_CPU_CYCLES, 4, clocks the CPU owns the bus after a DMA release before HOLD is honoured again; legal range 0-15.

Ports:
CORE_CLK_INT  in  1  core clock; all state changes on its rising edge
RESET_INT  in  1  synchronous, active-high reset
CPU_ALE, CPU_RD_n, CPU_WR_n, CPU_IOM, CPU_INTA_n, CPU_DTR, CPU_DEN, CPU_AD_OE  in  1 each  CPU bus pins
CPU_AD_OUT  in  20  CPU address/data out
CPU_LOCK  in  1  CPU lock prefix active; no grant while high
CPU_READY  out  1  to CPU READY_IN
DMA_HOLD  in  1  bus request from secondary master
DMA_HLDA  out  1  bus grant, registered
DMA_ALE, DMA_RD_n, DMA_WR_n, DMA_IOM, DMA_AD_OE  in  1 each  secondary master bus pins
DMA_AD_OUT  in  20  secondary master address/data
DMA_READY  out  1  ready to secondary master
BUS_READY  in  1  system ready
BUS_ALE, BUS_RD_n, BUS_WR_n, BUS_IOM, BUS_INTA_n, BUS_DTR, BUS_DEN, BUS_AD_OE  out  1 each  system bus
BUS_AD_OUT  out  20  system address/data
BUS_OWNER  out  1  0=CPU, 1=DMA, registered

Behaviour:
- States: CPU_OWN, DEAD_TO_DMA, DMA_OWN, DEAD_TO_CPU, CPU_REPLAY. Reset state is CPU_OWN.
- Reset values: DMA_HLDA=0, BUS_OWNER=0, pend=0, guard counter=0, cpu_busy=0, inta_half=0. Reset mid-DMA returns to CPU_OWN on the next edge with no dead cycles.
- Idle bus value: BUS_ALE=0, BUS_RD_n=BUS_WR_n=BUS_INTA_n=1, BUS_DEN=1, BUS_DTR=0, BUS_AD_OE=0, BUS_AD_OUT=0. Driven in both dead states.
- CPU_OWN: all BUS_* are a combinational pass-through of CPU_*, and CPU_READY=BUS_READY.
- DMA_OWN: BUS_* are driven from DMA_*. BUS_INTA_n=1. BUS_DTR=~DMA_WR_n. BUS_DEN=DMA_RD_n&DMA_WR_n. DMA_READY=BUS_READY. DMA_READY=0 in every other state.
- CPU cycle tracking, in CPU_OWN and CPU_REPLAY:
  - CPU_ALE=1 sets cpu_busy.
  - Any strobe low (RD_n/WR_n/INTA_n) sets strobe_seen.
  - When strobe_seen=1 and all strobes are high, both flags clear.
  - Completion of an INTA cycle toggles inta_half. While inta_half=1 the pair is still open and counts as busy.
- Grant condition, evaluated in CPU_OWN: DMA_HOLD=1, cpu_busy=0, inta_half=0, CPU_LOCK=0, CPU_ALE=0 this cycle, guard=0.
  - If it holds, go to DEAD_TO_DMA for DEAD_CYCLES clocks, then DMA_OWN.
  - DMA_HLDA and BUS_OWNER go to 1 on entry to DMA_OWN, not earlier.
  - CPU_ALE in the same cycle as HOLD: the CPU wins.
- Release: in DMA_OWN, DMA_HOLD=0 drops DMA_HLDA on the next edge and enters DEAD_TO_CPU for DEAD_CYCLES clocks. Next state is CPU_REPLAY if pend=1, else CPU_OWN. Guard loads MIN_CPU_CYCLES on that transition and decrements to 0 in CPU_OWN/CPU_REPLAY.
- Stalled CPU cycle:
  - CPU_ALE=1 in any state other than CPU_OWN/CPU_REPLAY latches CPU_AD_OUT and CPU_IOM into replay registers and sets pend.
  - CPU_READY=0 whenever the state is not CPU_OWN/CPU_REPLAY.
  - CPU_ALE with pend already set is a protocol error and is ignored.
- CPU_REPLAY lasts exactly one clock:
  - BUS_ALE=1, BUS_AD_OE=1, BUS_AD_OUT/BUS_IOM come from the replay registers. Strobes are idle and CPU_READY=0.
  - Then pend clears, cpu_busy sets, and the state moves to CPU_OWN with normal pass-through.
- HOLD while pend=1 and guard>0 is held off until guard reaches 0 and the replayed cycle completes.

Test Plan:
1. Reset, then HOLD=1 with the CPU idle -> HLDA=1 and BUS_OWNER=1 at clock 1+DEAD_CYCLES (2 with defaults). The bus is idle on the dead clock.
2. CPU_ALE=1 with address 0xF0010 in the same cycle HOLD rises -> CPU keeps the bus. HLDA rises only DEAD_CYCLES+1 clocks after the CPU strobes return high.
3. During DMA_OWN, CPU_ALE=1 with CPU_AD_OUT=0x12345, IOM=0. DMA drops HOLD 5 clocks later -> CPU_READY=0 throughout. HLDA falls one clock after HOLD drops, followed by 1 dead clock. Then one CPU_REPLAY clock with BUS_ALE=1 and BUS_AD_OUT=0x12345. CPU_READY then follows BUS_READY.
4. INTA pair: HOLD asserted between the two INTA cycles -> no grant until the second INTA_n returns high. Same with CPU_LOCK=1: no grant while LOCK is high.
5. DMA releases HOLD and immediately reasserts it -> the CPU owns the bus for at least MIN_CPU_CYCLES=4 clocks before the next DEAD_TO_DMA.
6. RESET_INT=1 during DMA_OWN with pend=1 -> next edge: HLDA=0, BUS_OWNER=0, pend=0, pass-through from the CPU, and no replay ALE.
